// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;
  localparam int WB_AW   = 5;
  localparam int WB_DW   = 32;
  localparam int WB_NREG = 1 << WB_AW;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Arbiter bus: pipeline write request, secondary result handshake, scoreboard hooks, RF write port.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic               p_we;
  logic [WB_AW-1:0]   p_rd;
  logic [WB_DW-1:0]   p_wd;
  logic               p_stall;
  logic               m_valid;
  logic               m_ready;
  logic [WB_AW-1:0]   m_rd;
  logic [WB_DW-1:0]   m_wd;
  logic               iss_valid;
  logic [WB_AW-1:0]   iss_rd;
  logic [WB_AW-1:0]   rs1;
  logic [WB_AW-1:0]   rs2;
  logic [WB_NREG-1:0] busy_mask;
  logic               RFWr;
  logic [WB_AW-1:0]   A3;
  logic [WB_DW-1:0]   WD;

  modport master (
    output p_we, p_rd, p_wd, m_valid, m_rd, m_wd, iss_valid, iss_rd, rs1, rs2,
    input  p_stall, m_ready, busy_mask, RFWr, A3, WD
  );

  modport slave (
    input  p_we, p_rd, p_wd, m_valid, m_rd, m_wd, iss_valid, iss_rd, rs1, rs2,
    output p_stall, m_ready, busy_mask, RFWr, A3, WD
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback entries; head readable combinationally, push then pop visible next cycle.
// Push ignored when full, pop ignored when empty; no same-cycle bypass.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_dat,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges pipeline and long-latency results onto the RF write port (RFWr/A3/WD one cycle after selection);
// secondary side backpressured by m_ready; RF_WB_SCOREBOARD_EN adds busy_mask and hazard stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [SW-1:0]      starve_cnt;
  logic [SW-1:0]      starve_nxt;
  wb_entry_t          m_ent;
  wb_entry_t          head;
  wb_entry_t          sel;
  logic               sel_vld;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [CW-1:0]      fifo_count_unused;
  logic [WB_NREG-1:0] busy;
  logic               hazard;
  logic               rf_we;
  logic [WB_AW-1:0]   rf_a3;
  logic [WB_DW-1:0]   rf_wd;

  assign m_ent        = '{rd: bus.m_rd, wd: bus.m_wd};
  assign push         = bus.m_valid && !full;
  assign bus.m_ready  = !full;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (m_ent),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count_unused)
  );

  // Forced drain is entered on the cycle the run of primary wins reaches STARVE_MAX,
  // so exactly STARVE_MAX primary writes precede it.
  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    pop        = 1'b0;
    sel_vld    = 1'b0;
    sel        = head;
    case (state)
      NORMAL: begin
        if (bus.p_we) begin
          sel_vld = 1'b1;
          sel     = '{rd: bus.p_rd, wd: bus.p_wd};
          if (!empty) begin
            starve_nxt = starve_cnt + SW'(1);
            if (starve_cnt == SW'(STARVE_MAX - 1)) state_nxt = FORCE;
          end
        end else if (!empty) begin
          pop     = 1'b1;
          sel_vld = 1'b1;
        end
      end
      FORCE: begin
        pop       = !empty;
        sel_vld   = !empty;
        state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd      <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rf_we      <= sel_vld && (sel.rd != '0);
      if (sel_vld && (sel.rd != '0)) begin
        rf_a3 <= sel.rd;
        rf_wd <= sel.wd;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [WB_NREG-1:0] set_mask;
  logic [WB_NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && (bus.iss_rd != '0)) set_mask[bus.iss_rd] = 1'b1;
    if (pop && (head.rd != '0))              clr_mask[head.rd]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_mask) | set_mask;
  end

  assign hazard = ((bus.rs1 != '0) && busy[bus.rs1]) || ((bus.rs2 != '0) && busy[bus.rs2]);
`else
  logic unused_sb;
  assign unused_sb = ^{bus.iss_valid, bus.iss_rd, bus.rs1, bus.rs2};
  assign busy      = '0;
  assign hazard    = 1'b0;
`endif

  assign bus.busy_mask = busy;
  assign bus.p_stall   = (state == FORCE) || hazard;
  assign bus.RFWr      = rf_we;
  assign bus.A3        = rf_a3;
  assign bus.WD        = rf_wd;
endmodule
